bank_biu_linefill: RTL and testbench
====================================

BANK_BIU_LINEFILL -- requirements
Module: bank_biu_linefill

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, request-queue entries (power of two).
REQ-002 Parameter: MAX_OUTSTANDING, default 8, AR issued but not yet delivered to ISU.
REQ-003 clk_i  in  1  single clock; every flop on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 htu_biu_valid_i / htu_biu_ready_o  in/out  1/1  linefill request handshake from HTU.
REQ-006 htu_biu_addr_i  in  32  line address, 32-byte aligned; bits [4:0] ignored and driven 0 on AR.
REQ-007 htu_biu_set_i / htu_biu_way_i  in  3/3  target set/way of the line.
REQ-008 axi_arvalid_o / axi_arready_i  out/in  1/1  AXI read-address handshake.
REQ-009 axi_araddr_o  out  32; axi_arid_o  out  6 = {set,way}; axi_arlen_o  out  8 = 1; axi_arsize_o  out  3 = 4; axi_arburst_o  out  2 = INCR.
REQ-010 axi_rvalid_i / axi_rready_o  in/out  1/1; axi_rdata_i  in  128; axi_rid_i  in  6; axi_rlast_i  in  1; axi_rresp_i  in  2.
REQ-011 biu_isu_rvalid_o / biu_isu_rready_i  out/in  1/1  line delivery to ISU.
REQ-012 biu_isu_rdata_o  out  256; biu_isu_rid_o  out  6 = {set[5:3],way[2:0]}.
REQ-013 biu_rresp_err_o  out  1  sticky bus-error flag; see Configuration.

Function
REQ-014 Request FIFO: push on valid&ready; htu_biu_ready_o = ~full; full/empty via wrapping pointers with one extra bit.
REQ-015 axi_arvalid_o = ~fifo_empty & (outstanding < MAX_OUTSTANDING); AR fields taken from FIFO head; pop on arvalid&arready.
REQ-016 Once asserted, arvalid and AR fields hold stable until arready.
REQ-017 Latency: request accepted in cycle N, earliest arvalid in cycle N+1.
REQ-018 Outstanding counter: +1 on AR handshake, -1 on ISU handshake, unchanged when both occur; never exceeds MAX_OUTSTANDING.
REQ-019 Beat assembly: R beat with rlast=0 stores rdata into low half [127:0] and latches rid; beat with rlast=1 stores the high half [255:127+1] and completes the line.
REQ-020 Beats from different IDs do not interleave; a completing beat whose rid differs from the latched rid is still accepted and sets biu_rresp_err_o (when compiled in).
REQ-021 Output register: completion in cycle M raises biu_isu_rvalid_o in M+1 with the full 256-bit line and rid; held until biu_isu_rready_i.
REQ-022 axi_rready_o = ~rvalid_out | biu_isu_rready_i for rlast beats; always 1 for first beats; no line lost or overwritten.
REQ-023 Simultaneous output handshake and new completion: output reloads back-to-back with no bubble.
REQ-024 Empty FIFO with outstanding=0: all valid outputs low.

Reset
REQ-025 On rst_i: FIFO empty, outstanding=0, assembly state idle, biu_isu_rvalid_o=0, axi_arvalid_o=0, htu_biu_ready_o=1 after reset deassertion, biu_rresp_err_o=0.
REQ-026 Reset mid-burst discards partial lines and queued requests; no output pulse follows reset.

Configuration
REQ-027 Macro BANK_BIU_RRESP_ERR_EN: when defined, biu_rresp_err_o sets on any R beat with rresp!=0 or on an rid mismatch (REQ-020) and clears only on reset.
REQ-028 Without BANK_BIU_RRESP_ERR_EN: port present, tied 0, no error logic; data path identical.

Verification
REQ-029 Single request addr=0x1000_0020, set=2, way=5, arready=1 -> AR next cycle, arid=0x15, araddr=0x1000_0020; beats 0xA..,0xB.. -> rvalid with rdata={B,A}, rid=0x15.
REQ-030 Five requests, arready=0 -> ready_o low after 4 accepted; the 5th waits until the first AR handshake.
REQ-031 Nine requests, no R traffic -> exactly 8 AR handshakes; 9th issues after the first ISU handshake.
REQ-032 biu_isu_rready_i=0 with a line pending -> rlast beat stalls (rready_o=0), first beat accepted; release -> two lines delivered back-to-back.
REQ-033 rresp=2'b10 on the first beat, macro on -> err=1 sticky through later lines; macro off -> err stays 0.
REQ-034 rst_i asserted after the first beat -> rvalid stays 0, FIFO empty, outstanding=0; next request completes normally.

Source files
------------

// File: rtl/bank_biu_linefill.sv
// Linefill bus interface: queues HTU line requests, issues 2-beat AXI reads and delivers 256-bit
// lines to the ISU. Define BANK_BIU_RRESP_ERR_EN to build the sticky bus-error flag. FIFO_DEPTH >= 2.
module bank_biu_linefill #(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         htu_biu_valid_i,
  output logic         htu_biu_ready_o,
  input  logic [31:0]  htu_biu_addr_i,
  input  logic [2:0]   htu_biu_set_i,
  input  logic [2:0]   htu_biu_way_i,
  output logic         axi_arvalid_o,
  input  logic         axi_arready_i,
  output logic [31:0]  axi_araddr_o,
  output logic [5:0]   axi_arid_o,
  output logic [7:0]   axi_arlen_o,
  output logic [2:0]   axi_arsize_o,
  output logic [1:0]   axi_arburst_o,
  input  logic         axi_rvalid_i,
  output logic         axi_rready_o,
  input  logic [127:0] axi_rdata_i,
  input  logic [5:0]   axi_rid_i,
  input  logic         axi_rlast_i,
  input  logic [1:0]   axi_rresp_i,
  output logic         biu_isu_rvalid_o,
  input  logic         biu_isu_rready_i,
  output logic [255:0] biu_isu_rdata_o,
  output logic [5:0]   biu_isu_rid_o,
  output logic         biu_rresp_err_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned EW = 33;
  localparam logic [PW:0]   PTR_ONE = {{PW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  // Request FIFO entry: {addr[31:5], set, way}
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  logic [CW-1:0] outstanding;
  logic          ar_ok;

  logic          r_hs;
  logic          first_hs;
  logic          last_hs;
  logic [127:0]  low_data;
  logic [5:0]    lat_rid;

  logic          out_valid;
  logic [255:0]  out_data;
  logic [5:0]    out_rid;
  logic          isu_hs;

  logic          unused_addr;

  assign unused_addr = ^htu_biu_addr_i[4:0];

  assign fifo_empty      = (wr_ptr == rd_ptr);
  assign fifo_full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign htu_biu_ready_o = ~fifo_full;
  assign push            = htu_biu_valid_i & ~fifo_full;
  assign pop             = axi_arvalid_o & axi_arready_i;
  assign head            = fifo_mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr[PW-1:0]] <= {htu_biu_addr_i[31:5], htu_biu_set_i, htu_biu_way_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // AR only depends on registered state, so fields stay stable until arready.
  assign ar_ok         = (outstanding < CNT_MAX);
  assign axi_arvalid_o = ~fifo_empty & ar_ok;
  assign axi_araddr_o  = {head[32:6], 5'b00000};
  assign axi_arid_o    = head[5:0];
  assign axi_arlen_o   = 8'd1;
  assign axi_arsize_o  = 3'd4;
  assign axi_arburst_o = 2'b01;

  assign isu_hs = out_valid & biu_isu_rready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding <= '0;
    end else begin
      unique case ({pop, isu_hs})
        2'b10:   outstanding <= outstanding + CNT_ONE;
        2'b01:   outstanding <= outstanding - CNT_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // First beats never stall; the completing beat waits for room in the output register.
  assign axi_rready_o = ~axi_rlast_i | ~out_valid | biu_isu_rready_i;
  assign r_hs         = axi_rvalid_i & axi_rready_o;
  assign first_hs     = r_hs & ~axi_rlast_i;
  assign last_hs      = r_hs & axi_rlast_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      low_data <= '0;
      lat_rid  <= '0;
    end else if (first_hs) begin
      low_data <= axi_rdata_i;
      lat_rid  <= axi_rid_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_rid   <= '0;
    end else if (last_hs) begin
      out_valid <= 1'b1;
      out_data  <= {axi_rdata_i, low_data};
      out_rid   <= lat_rid;
    end else if (isu_hs) begin
      out_valid <= 1'b0;
    end
  end

  assign biu_isu_rvalid_o = out_valid;
  assign biu_isu_rdata_o  = out_data;
  assign biu_isu_rid_o    = out_rid;

`ifdef BANK_BIU_RRESP_ERR_EN
  logic rresp_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rresp_err <= 1'b0;
    end else if ((r_hs && (axi_rresp_i != 2'b00)) || (last_hs && (axi_rid_i != lat_rid))) begin
      rresp_err <= 1'b1;
    end
  end

  assign biu_rresp_err_o = rresp_err;
`else
  logic unused_rresp;

  assign unused_rresp    = ^axi_rresp_i;
  assign biu_rresp_err_o = 1'b0;
`endif

  property p_outstanding_bound;
    @(posedge clk_i) disable iff (rst_i) outstanding <= CNT_MAX;
  endproperty
  a_outstanding_bound: assert property (p_outstanding_bound);

  property p_no_line_overwrite;
    @(posedge clk_i) disable iff (rst_i) !(last_hs && out_valid && !biu_isu_rready_i);
  endproperty
  a_no_line_overwrite: assert property (p_no_line_overwrite);

endmodule

// File: tb/tb_bank_biu_linefill.sv
// Bench for bank_biu_linefill: transaction-level model (counts and queues) checked every cycle,
// randomized traffic plus directed scenarios with literal expectations.
module tb_bank_biu_linefill;

  localparam int DEPTH = 4;
  localparam int MAXO  = 8;
`ifdef BANK_BIU_RRESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         htu_biu_valid_i;
  logic         htu_biu_ready_o;
  logic [31:0]  htu_biu_addr_i;
  logic [2:0]   htu_biu_set_i;
  logic [2:0]   htu_biu_way_i;
  logic         axi_arvalid_o;
  logic         axi_arready_i;
  logic [31:0]  axi_araddr_o;
  logic [5:0]   axi_arid_o;
  logic [7:0]   axi_arlen_o;
  logic [2:0]   axi_arsize_o;
  logic [1:0]   axi_arburst_o;
  logic         axi_rvalid_i;
  logic         axi_rready_o;
  logic [127:0] axi_rdata_i;
  logic [5:0]   axi_rid_i;
  logic         axi_rlast_i;
  logic [1:0]   axi_rresp_i;
  logic         biu_isu_rvalid_o;
  logic         biu_isu_rready_i;
  logic [255:0] biu_isu_rdata_o;
  logic [5:0]   biu_isu_rid_o;
  logic         biu_rresp_err_o;

  bank_biu_linefill #(
    .FIFO_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .htu_biu_valid_i  (htu_biu_valid_i),
    .htu_biu_ready_o  (htu_biu_ready_o),
    .htu_biu_addr_i   (htu_biu_addr_i),
    .htu_biu_set_i    (htu_biu_set_i),
    .htu_biu_way_i    (htu_biu_way_i),
    .axi_arvalid_o    (axi_arvalid_o),
    .axi_arready_i    (axi_arready_i),
    .axi_araddr_o     (axi_araddr_o),
    .axi_arid_o       (axi_arid_o),
    .axi_arlen_o      (axi_arlen_o),
    .axi_arsize_o     (axi_arsize_o),
    .axi_arburst_o    (axi_arburst_o),
    .axi_rvalid_i     (axi_rvalid_i),
    .axi_rready_o     (axi_rready_o),
    .axi_rdata_i      (axi_rdata_i),
    .axi_rid_i        (axi_rid_i),
    .axi_rlast_i      (axi_rlast_i),
    .axi_rresp_i      (axi_rresp_i),
    .biu_isu_rvalid_o (biu_isu_rvalid_o),
    .biu_isu_rready_i (biu_isu_rready_i),
    .biu_isu_rdata_o  (biu_isu_rdata_o),
    .biu_isu_rid_o    (biu_isu_rid_o),
    .biu_rresp_err_o  (biu_rresp_err_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Model state: requests not yet sent ({addr,set,way}), queued in DUT, AR ids awaiting data,
  // completed lines awaiting delivery ({rid,hi,lo}).
  logic [37:0]  stim_q [$];
  logic [37:0]  req_q [$];
  logic [5:0]   rd_q [$];
  logic [261:0] line_q [$];
  int           fifo_cnt, outst;
  bit           exp_err;

  int           p_req, p_arready, p_rvalid, p_isu;
  int           r_phase;
  logic [5:0]   cur_id;
  logic [127:0] cur_lo, cur_hi;
  logic [1:0]   inj_resp;
  bit           inj_badid;
  bit           dir_data;

  int           ar_count, isu_count, push_count;
  int           last_push_cyc, first_ar_cyc, last_ar_cyc, first_isu_cyc, last_isu_cyc, prev_isu_cyc;
  logic [31:0]  last_araddr;
  logic [5:0]   last_arid;
  logic [255:0] last_line;
  logic [5:0]   last_rid;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event with no model entry (cycle %0d)", name, cyc);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [37:0] rand_req();
    return {$urandom(), 3'($urandom_range(7)), 3'($urandom_range(7))};
  endfunction

  task automatic step();
    logic [37:0]  r;
    logic [261:0] el;
    bit push, ar_hs, isu_hs, r_hs;
    @(posedge clk);
    #1;
    cyc++;
    htu_biu_valid_i = (stim_q.size() > 0) && ($urandom_range(99) < p_req);
    if (stim_q.size() > 0) {htu_biu_addr_i, htu_biu_set_i, htu_biu_way_i} = stim_q[0];
    axi_arready_i = ($urandom_range(99) < p_arready);
    if (r_phase == 0 && rd_q.size() > 0 && $urandom_range(99) < p_rvalid) begin
      cur_id  = rd_q.pop_front();
      cur_lo  = dir_data ? {4{32'hAAAA_AAAA}} : rand128();
      r_phase = 1;
    end
    axi_rvalid_i     = (r_phase != 0);
    axi_rlast_i      = (r_phase == 2);
    axi_rid_i        = (r_phase == 2 && inj_badid) ? (cur_id ^ 6'h01) : cur_id;
    axi_rdata_i      = (r_phase == 2) ? cur_hi : cur_lo;
    axi_rresp_i      = (r_phase == 1) ? inj_resp : 2'b00;
    biu_isu_rready_i = ($urandom_range(99) < p_isu);
    #3;
    check("htu_ready", htu_biu_ready_o, fifo_cnt < DEPTH);
    check("arvalid", axi_arvalid_o, (fifo_cnt > 0) && (outst < MAXO));
    check("isu_rvalid", biu_isu_rvalid_o, line_q.size() > 0);
    check("rresp_err", biu_rresp_err_o, exp_err);
    if (axi_rvalid_i)
      check("axi_rready", axi_rready_o,
            !axi_rlast_i || (line_q.size() == 0) || biu_isu_rready_i);

    isu_hs = biu_isu_rvalid_o && biu_isu_rready_i;
    ar_hs  = axi_arvalid_o && axi_arready_i;
    push   = htu_biu_valid_i && htu_biu_ready_o;
    r_hs   = axi_rvalid_i && axi_rready_o;

    if (isu_hs) begin
      if (line_q.size() == 0) fail("isu_unexpected");
      else begin
        el = line_q.pop_front();
        check("isu_rdata", biu_isu_rdata_o, el[255:0]);
        check("isu_rid", biu_isu_rid_o, el[261:256]);
      end
      isu_count++;
      if (isu_count == 1) first_isu_cyc = cyc;
      prev_isu_cyc = last_isu_cyc;
      last_isu_cyc = cyc;
      last_line    = biu_isu_rdata_o;
      last_rid     = biu_isu_rid_o;
    end
    if (ar_hs) begin
      if (req_q.size() == 0) fail("ar_unexpected");
      else begin
        r = req_q.pop_front();
        check("araddr", axi_araddr_o, {r[37:11], 5'b00000});
        check("arid", axi_arid_o, r[5:0]);
        check("arlen", axi_arlen_o, 8'd1);
        check("arsize", axi_arsize_o, 3'd4);
        check("arburst", axi_arburst_o, 2'b01);
        rd_q.push_back(r[5:0]);
      end
      ar_count++;
      if (ar_count == 1) first_ar_cyc = cyc;
      last_ar_cyc = cyc;
      last_araddr = axi_araddr_o;
      last_arid   = axi_arid_o;
    end
    if (push) begin
      req_q.push_back(stim_q.pop_front());
      push_count++;
      last_push_cyc = cyc;
    end
    if (r_hs) begin
      if (r_phase == 1) begin
        if (axi_rresp_i != 2'b00) exp_err = exp_err | ERR_EN;
        cur_hi  = dir_data ? {4{32'hBBBB_BBBB}} : rand128();
        r_phase = 2;
      end else begin
        line_q.push_back({cur_id, cur_hi, cur_lo});
        if (inj_badid) exp_err = exp_err | ERR_EN;
        r_phase = 0;
      end
    end
    fifo_cnt += int'(push) - int'(ar_hs);
    outst    += int'(ar_hs) - int'(isu_hs);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    htu_biu_valid_i = 0; htu_biu_addr_i = '0; htu_biu_set_i = '0; htu_biu_way_i = '0;
    axi_arready_i = 0; axi_rvalid_i = 0; axi_rdata_i = '0; axi_rid_i = '0; axi_rlast_i = 0;
    axi_rresp_i = '0; biu_isu_rready_i = 0;
    stim_q.delete(); req_q.delete(); rd_q.delete(); line_q.delete();
    fifo_cnt = 0; outst = 0; exp_err = 0; r_phase = 0;
    inj_resp = '0; inj_badid = 0;
    ar_count = 0; isu_count = 0; push_count = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #3;
    check("rst_htu_ready", htu_biu_ready_o, 1'b1);
    check("rst_arvalid", axi_arvalid_o, 1'b0);
    check("rst_isu_rvalid", biu_isu_rvalid_o, 1'b0);
    check("rst_err", biu_rresp_err_o, 1'b0);
  endtask

  task automatic wait_isu(input int n, input int budget);
    int k = 0;
    while (isu_count < n && k < budget) begin
      step();
      k++;
    end
    tests++;
    if (isu_count < n) begin
      fails++;
      $display("FAIL wait_isu: got %0d lines, required %0d (cycle %0d)", isu_count, n, cyc);
    end
  endtask

  task automatic set_probs(input int rq, input int ar, input int rv, input int is);
    p_req = rq; p_arready = ar; p_rvalid = rv; p_isu = is;
  endtask

  initial begin
    rst = 1'b1;
    dir_data = 1'b1;
    set_probs(100, 100, 100, 100);
    do_reset();

    // Single line with literal fields and data, then a misaligned address.
    stim_q.push_back({32'h1000_0020, 3'd2, 3'd5});
    wait_isu(1, 50);
    check("t1_araddr", last_araddr, 32'h1000_0020);
    check("t1_arid", last_arid, 6'h15);
    check("t1_ar_latency", last_ar_cyc - last_push_cyc, 1);
    check("t1_line", last_line, {{4{32'hBBBB_BBBB}}, {4{32'hAAAA_AAAA}}});
    check("t1_rid", last_rid, 6'h15);
    stim_q.push_back({32'h2000_001F, 3'd7, 3'd0});
    wait_isu(2, 50);
    check("t1_araddr_align", last_araddr, 32'h2000_0000);
    check("t1_rid2", last_rid, 6'h38);

    // FIFO full with arready low.
    do_reset();
    set_probs(100, 0, 0, 100);
    repeat (5) stim_q.push_back(rand_req());
    repeat (8) step();
    check("t2_accepted", push_count, 4);
    check("t2_ready_low", htu_biu_ready_o, 1'b0);
    p_arready = 100;
    repeat (8) step();
    check("t2_accepted_all", push_count, 5);
    check("t2_fifth_after_ar", last_push_cyc - first_ar_cyc, 1);

    // Outstanding limit.
    do_reset();
    set_probs(100, 100, 0, 100);
    repeat (9) stim_q.push_back(rand_req());
    repeat (30) step();
    check("t3_ar_limit", ar_count, 8);
    check("t3_arvalid_held", axi_arvalid_o, 1'b0);
    p_rvalid = 100;
    wait_isu(9, 200);
    check("t3_ar_total", ar_count, 9);
    check("t3_ninth_after_isu", last_ar_cyc - first_isu_cyc, 1);

    // Output back-pressure, then back-to-back delivery.
    do_reset();
    set_probs(100, 100, 100, 0);
    repeat (2) stim_q.push_back(rand_req());
    repeat (20) step();
    check("t4_no_delivery", isu_count, 0);
    check("t4_rvalid_held", biu_isu_rvalid_o, 1'b1);
    check("t4_first_beat_taken", r_phase, 2);
    check("t4_rlast_stalled", axi_rready_o, 1'b0);
    p_isu = 100;
    wait_isu(2, 20);
    check("t4_back_to_back", last_isu_cyc - prev_isu_cyc, 1);

    // Error flag: bad rresp on a first beat, sticky; then rid mismatch alone.
    do_reset();
    set_probs(100, 100, 100, 100);
    inj_resp = 2'b10;
    stim_q.push_back(rand_req());
    wait_isu(1, 50);
    inj_resp = 2'b00;
    check("t5_err_set", biu_rresp_err_o, ERR_EN);
    repeat (2) stim_q.push_back(rand_req());
    wait_isu(3, 80);
    check("t5_err_sticky", biu_rresp_err_o, ERR_EN);
    do_reset();
    inj_badid = 1'b1;
    stim_q.push_back({32'h3000_0040, 3'd1, 3'd3});
    wait_isu(1, 50);
    inj_badid = 1'b0;
    check("t5_err_rid", biu_rresp_err_o, ERR_EN);
    check("t5_rid_latched", last_rid, 6'h0B);

    // Reset after the first beat of a line.
    do_reset();
    set_probs(100, 100, 100, 0);
    dir_data = 1'b0;
    stim_q.push_back(rand_req());
    for (int k = 0; k < 20 && r_phase != 2; k++) step();
    check("t6_mid_burst", r_phase, 2);
    do_reset();
    repeat (5) step();
    check("t6_no_pulse", isu_count, 0);
    p_isu = 100;
    stim_q.push_back({32'h4000_0080, 3'd4, 3'd6});
    wait_isu(1, 50);
    check("t6_after_reset_rid", last_rid, 6'h26);

    // Randomized traffic, two mixes.
    do_reset();
    set_probs(70, 60, 50, 50);
    repeat (300) stim_q.push_back(rand_req());
    wait_isu(300, 20000);
    do_reset();
    set_probs(90, 90, 90, 20);
    repeat (200) stim_q.push_back(rand_req());
    wait_isu(200, 20000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
